if_fetch_unit: RTL

Instruction-fetch stage that owns the program counter, drives the instruction-memory request/ready handshake, and feeds the IF/ID pipeline register. Every cycle it presents an instruction word, its PC+4, and the IF/ID write-enable and flush controls. It handles memory wait states, hazard stalls (hold) and branch/jump redirects (squash). One memory request is outstanding at most.

---
 rtl/if_fetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, imem handshake, IF/ID controls
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_add4_o,
  output logic        ifid_write_o,
  output logic        flush_o,
  output logic [31:0] pc_o
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic [31:0] stale_addr_q, stale_addr_d;

  logic [31:0] pc_add4;
  logic [31:0] target;
  logic        unused_low_bits;

  assign pc_add4         = pc_q + 32'd4;
  assign target          = {redirect_pc_i[31:2], 2'b00};
  assign unused_low_bits = ^redirect_pc_i[1:0];
  assign pc_o            = pc_q;

  // State, PC, held word and stale request address; reset abandons any request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      hold_buf_q   <= 32'h0;
      stale_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_buf_q   <= hold_buf_d;
      stale_addr_q <= stale_addr_d;
    end
  end

  // Next state and per-cycle outputs; redirect beats stall beats normal flow
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_buf_d   = hold_buf_q;
    stale_addr_d = stale_addr_q;
    imem_req_o   = 1'b0;
    imem_addr_o  = 32'h0;
    inst_o       = 32'h0;
    pc_add4_o    = 32'h0;
    ifid_write_o = 1'b0;
    flush_o      = 1'b0;

    case (state_q)
      BOOT: begin
        flush_o = redirect_i;
        state_d = FETCH;
        if (redirect_i) pc_d = target;
      end

      FETCH: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_q;
        inst_o      = imem_rdata_i;
        pc_add4_o   = pc_add4;
        if (redirect_i) begin
          // The in-flight request must still complete; remember where it went
          pc_d    = target;
          flush_o = 1'b1;
          if (!imem_ready_i) begin
            state_d      = DISCARD;
            stale_addr_d = pc_q;
          end
        end else if (imem_ready_i) begin
          if (!stall_i) begin
            ifid_write_o = 1'b1;
            pc_d         = pc_add4;
          end else begin
            hold_buf_d = imem_rdata_i;
            state_d    = HOLD;
          end
        end else begin
          flush_o = !stall_i;
        end
      end

      HOLD: begin
        inst_o    = hold_buf_q;
        pc_add4_o = pc_add4;
        if (redirect_i) begin
          pc_d    = target;
          flush_o = 1'b1;
          state_d = FETCH;
        end else if (!stall_i) begin
          ifid_write_o = 1'b1;
          pc_d         = pc_add4;
          state_d      = FETCH;
        end
      end

      DISCARD: begin
        imem_req_o  = 1'b1;
        imem_addr_o = stale_addr_q;
        flush_o     = redirect_i || !stall_i;
        if (redirect_i) pc_d = target;
        if (imem_ready_i) state_d = FETCH;
      end

      default: state_d = BOOT;
    endcase
  end

endmodule
